ntt_stream_port: RTL and testbench
==================================

NTT_STREAM_PORT -- requirements
Module: ntt_stream_port

Interface
REQ-001 Parameter DATA_SIZE, default 64, coefficient width in bits.
REQ-002 Parameter RING_DEPTH, default 10, log2 of ring size; RING_SIZE = 2^RING_DEPTH.
REQ-003 Parameter PE_DEPTH, default 3, log2 of PE count; LANES = 2^(PE_DEPTH+1), ROWS = RING_SIZE/LANES, ROW_W = RING_DEPTH-PE_DEPTH-1.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 load  in  1  one-cycle pulse, starts serial load of RING_SIZE coefficients.
REQ-008 unload  in  1  one-cycle pulse, starts serial unload of RING_SIZE coefficients.
REQ-009 din / din_valid  in  DATA_SIZE / 1  serial coefficient input, qualified by din_valid.
REQ-010 bram_we / bram_waddr / bram_wdata  out  1 / ROW_W / LANES*DATA_SIZE  row write port; lane j at bits [j*DATA_SIZE +: DATA_SIZE].
REQ-011 bram_raddr / bram_rdata  out / in  ROW_W / LANES*DATA_SIZE  row read port, read latency exactly 1 cycle.
REQ-012 dout / dout_valid / dout_ready  out / out / in  DATA_SIZE / 1 / 1  serial output stream, valid/ready handshake.
REQ-013 busy / done  out  1 / 1  busy high outside IDLE; done one-cycle pulse on completion of load or unload.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, RD, CAP, STREAM.
REQ-015 IDLE: load -> LOAD; else unload -> RD; load and unload together -> LOAD (unload dropped).
REQ-016 load/unload SHALL be ignored outside IDLE.
REQ-017 LOAD: each cycle with din_valid=1 SHALL place din (coefficient k, k=0..RING_SIZE-1) in lane L(k) of the row buffer, row k/LANES; din_valid=0 stalls with no state change.
REQ-018 L(k) = k mod LANES (natural order, see REQ-029).
REQ-019 On the cycle after the LANES-th word of a row is accepted, bram_we SHALL be 1 for exactly one cycle with bram_waddr = row and bram_wdata = completed row.
REQ-020 After the write of row ROWS-1, done SHALL pulse in the same cycle as that bram_we and FSM SHALL return to IDLE on the next cycle.
REQ-021 RD: bram_raddr = current row (starting at 0) for one cycle; CAP: bram_rdata captured into the output row register; then STREAM.
REQ-022 STREAM: dout = lane L(k) of captured row for coefficient k in increasing order; dout_valid=1; advance only on dout_valid & dout_ready.
REQ-023 While dout_valid=1 and dout_ready=0, dout SHALL hold stable.
REQ-024 After last lane of a row is accepted: row < ROWS-1 -> RD with row+1; row = ROWS-1 -> done pulse that cycle, IDLE next cycle.
REQ-025 Unload throughput: LANES beats per row plus 2 cycles RD/CAP overhead; load latency from last din to bram_we: 1 cycle.
REQ-026 Row and lane counters SHALL be sized exactly ROW_W and PE_DEPTH+1 bits and wrap to 0 at the end of an operation.

Reset
REQ-027 On reset: FSM=IDLE, counters=0, bram_we=0, dout_valid=0, done=0, busy=0, bram_waddr=0, bram_raddr=0, bram_wdata=0, dout=0.
REQ-028 Reset mid-operation SHALL discard any partial row (no bram_we issued) and abort the stream without a done pulse.

Configuration
REQ-029 Macro LANE_BITREV_EN: when defined, L(k) = bit-reversal of (k mod LANES) over PE_DEPTH+1 bits on both load and unload (round trip is identity); when undefined, L(k) = k mod LANES.

Verification
REQ-030 Params DATA_SIZE=16, RING_DEPTH=5, PE_DEPTH=1 (LANES=4, ROWS=8): load din=k for k=0..31, din_valid always 1 -> 8 bram_we pulses, row 0 wdata = 0x0003_0002_0001_0000, done with 8th write.
REQ-031 Same load with din_valid low every other cycle -> identical wdata, 8 writes, done ~64 cycles after load.
REQ-032 Unload from memory model holding k at coefficient k, dout_ready toggling 1/0 -> dout sequence 0..31, no duplicates or skips, dout stable while stalled, one done pulse.
REQ-033 Assert load and unload together in IDLE -> LOAD entered; unload pulse during LOAD -> ignored, busy stays 1.
REQ-034 Reset asserted after 6 words of a load -> one bram_we (row 0) only, busy=0, no done; new load then completes normally.
REQ-035 With LANE_BITREV_EN: load k=0..31 -> row 0 wdata = 0x0003_0001_0002_0000; unload returns 0..31 in order.

Source files
------------

// File: rtl/ntt_stream_port.sv
// Serial-to-row load and row-to-serial unload port between a coefficient stream and a row-wide BRAM.
// Define LANE_BITREV_EN to place coefficients in bit-reversed lane order (same mapping on load and unload).
module ntt_stream_port #(
    parameter int DATA_SIZE  = 64,
    parameter int RING_DEPTH = 10,
    parameter int PE_DEPTH   = 3,
    localparam int LANES  = 2 ** (PE_DEPTH + 1),
    localparam int ROWS   = (2 ** RING_DEPTH) / LANES,
    localparam int ROW_W  = RING_DEPTH - PE_DEPTH - 1,
    localparam int LANE_W = PE_DEPTH + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       unload,
    input  logic [DATA_SIZE-1:0]       din,
    input  logic                       din_valid,
    output logic                       bram_we,
    output logic [ROW_W-1:0]           bram_waddr,
    output logic [LANES*DATA_SIZE-1:0] bram_wdata,
    output logic [ROW_W-1:0]           bram_raddr,
    input  logic [LANES*DATA_SIZE-1:0] bram_rdata,
    output logic [DATA_SIZE-1:0]       dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {IDLE, LOAD, RD, CAP, STREAM} state_t;

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t                     state_q, state_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [LANES*DATA_SIZE-1:0] row_buf_q, row_buf_d;
    logic [LANES*DATA_SIZE-1:0] out_row_q, out_row_d;
    logic [ROW_W-1:0]           waddr_q, waddr_d;
    logic                       we_q, we_d;
    logic                       fin_q, fin_d;

    function automatic logic [LANE_W-1:0] lmap(input logic [LANE_W-1:0] k);
`ifdef LANE_BITREV_EN
        for (int i = 0; i < LANE_W; i++) lmap[i] = k[LANE_W-1-i];
`else
        lmap = k;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            lane_q    <= '0;
            row_buf_q <= '0;
            out_row_q <= '0;
            waddr_q   <= '0;
            we_q      <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            lane_q    <= lane_d;
            row_buf_q <= row_buf_d;
            out_row_q <= out_row_d;
            waddr_q   <= waddr_d;
            we_q      <= we_d;
            fin_q     <= fin_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        lane_d    = lane_q;
        row_buf_d = row_buf_q;
        out_row_d = out_row_q;
        waddr_d   = waddr_q;
        we_d      = 1'b0;
        fin_d     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load)        state_d = LOAD;
                else if (unload) state_d = RD;
            end
            LOAD: begin
                // fin_q marks the cycle carrying the final row write; no more words are taken
                if (fin_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (din_valid) begin
                    row_buf_d[lmap(lane_q)*DATA_SIZE +: DATA_SIZE] = din;
                    if (lane_q == LAST_LANE) begin
                        lane_d  = '0;
                        row_d   = row_q + ROW_W'(1);
                        we_d    = 1'b1;
                        waddr_d = row_q;
                        fin_d   = (row_q == LAST_ROW);
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                out_row_d = bram_rdata;
                state_d   = STREAM;
            end
            STREAM: begin
                if (dout_ready) begin
                    if (lane_q == LAST_LANE) begin
                        lane_d = '0;
                        row_d  = row_q + ROW_W'(1);
                        if (row_q == LAST_ROW) begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = RD;
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign dout_valid = (state_q == STREAM);
    assign dout       = out_row_q[lmap(lane_q)*DATA_SIZE +: DATA_SIZE];
    assign bram_raddr = row_q;
    assign bram_we    = we_q;
    assign bram_waddr = waddr_q;
    assign bram_wdata = row_buf_q;

endmodule

// File: tb/tb_ntt_stream_port.sv
// Scoreboard bench for ntt_stream_port with LANES=4, ROWS=8, 16-bit coefficients and a 1-cycle BRAM model.
module tb_ntt_stream_port;

    logic        clk = 1'b0;
    logic        reset, load, unload, din_valid, dout_ready;
    logic [15:0] din, dout;
    logic        bram_we, dout_valid, busy, done;
    logic [2:0]  bram_waddr, bram_raddr;
    logic [63:0] bram_wdata, bram_rdata;

    logic [63:0] mem [0:7];
    logic        pre_we;
    logic [2:0]  pre_addr;
    logic [63:0] pre_data;

    typedef struct { logic [2:0] addr; logic [63:0] data; logic dn; } wr_t;
    typedef struct { logic [15:0] d; logic dn; } rd_t;
    wr_t wq[$];
    rd_t dq[$];

    int n_cmp = 0, n_fail = 0, n_done = 0;
    int cyc = 0, last_done_cyc = 0, t0 = 0;

    ntt_stream_port #(.DATA_SIZE(16), .RING_DEPTH(5), .PE_DEPTH(1)) dut (
        .clk(clk), .reset(reset), .load(load), .unload(unload),
        .din(din), .din_valid(din_valid),
        .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
        .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pre_we)       mem[pre_addr]   <= pre_data;
        else if (bram_we) mem[bram_waddr] <= bram_wdata;
        bram_rdata <= mem[bram_raddr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lane j of a row holds coefficient 4r + lane_coef(j)
    function automatic int lane_coef(input int j);
`ifdef LANE_BITREV_EN
        lane_coef = ((j & 1) << 1) | ((j >> 1) & 1);
`else
        lane_coef = j;
`endif
    endfunction

    function automatic logic [63:0] exp_row(input int r, input int base, input int step);
        logic [31:0] v;
        exp_row = '0;
        for (int j = 0; j < 4; j++) begin
            v = base + step * (4 * r + lane_coef(j));
            exp_row[j*16 +: 16] = v[15:0];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_writes(input int base, input int step);
        wr_t e;
        for (int r = 0; r < 8; r++) begin
            e.addr = 3'(r);
            e.data = exp_row(r, base, step);
            e.dn   = (r == 7);
            wq.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check(name, {63'd0, busy}, 64'd0);
    endtask

    task automatic do_load(input int base, input int step, input bit gap, input int unload_at);
        logic [31:0] v;
        load = 1'b1;
        t0 = cyc;
        tick();
        load = 1'b0;
        for (int k = 0; k < 32; k++) begin
            v = base + step * k;
            din = v[15:0];
            din_valid = 1'b1;
            unload = (k == unload_at);
            tick();
            unload = 1'b0;
            if (k == unload_at) begin
                check("busy_after_unload_in_load", {63'd0, busy}, 64'd1);
                check("no_stream_in_load", {63'd0, dout_valid}, 64'd0);
            end
            if (gap) begin
                din_valid = 1'b0;
                tick();
            end
        end
        din_valid = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT writes a row or hands off a coefficient
    initial begin
        wr_t  e;
        rd_t  d;
        logic prev_stall = 1'b0;
        logic [15:0] prev_dout = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bram_we) begin
                    if (wq.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_write: addr %0d data 0x%0h, none required", bram_waddr, bram_wdata);
                    end else begin
                        e = wq.pop_front();
                        check("waddr", 64'(bram_waddr), 64'(e.addr));
                        check("wdata", bram_wdata, e.data);
                        check("load_done", {63'd0, done}, {63'd0, e.dn});
                    end
                end
                if (dout_valid && dout_ready) begin
                    if (dq.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_dout: got 0x%0h, none required", dout);
                    end else begin
                        d = dq.pop_front();
                        check("dout", 64'(dout), 64'(d.d));
                        check("unload_done", {63'd0, done}, {63'd0, d.dn});
                    end
                end
                if (prev_stall && dout_valid) check("dout_hold", 64'(dout), 64'(prev_dout));
                if (done && !bram_we && !(dout_valid && dout_ready)) begin
                    n_cmp++; n_fail++;
                    $display("FAIL stray_done: done=1 without write or handshake, required 0");
                end
                if (done) begin
                    n_done++;
                    last_done_cyc = cyc;
                end
                prev_stall = dout_valid && !dout_ready;
                prev_dout  = dout;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        rd_t d;
        reset = 1'b1; load = 1'b0; unload = 1'b0; din = '0; din_valid = 1'b0;
        dout_ready = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) tick();

        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_we",    {63'd0, bram_we}, 64'd0);
        check("rst_dvld",  {63'd0, dout_valid}, 64'd0);
        check("rst_done",  {63'd0, done}, 64'd0);
        check("rst_waddr", 64'(bram_waddr), 64'd0);
        check("rst_raddr", 64'(bram_raddr), 64'd0);
        check("rst_wdata", bram_wdata, 64'd0);
        check("rst_dout",  64'(dout), 64'd0);
        reset = 1'b0;
        tick();

        // Continuous load of k
        push_writes(0, 1);
        do_load(0, 1, 1'b0, -1);
        wait_idle("idle_after_load", 20);
        check("load_done_latency", 64'(last_done_cyc - t0), 64'd33);
`ifdef LANE_BITREV_EN
        check("row0_literal", mem[0], 64'h0003_0001_0002_0000);
`else
        check("row0_literal", mem[0], 64'h0003_0002_0001_0000);
`endif
        check("row7_stored", mem[7], exp_row(7, 0, 1));

        // Gapped load: din_valid every other cycle
        push_writes(0, 1);
        do_load(0, 1, 1'b1, -1);
        wait_idle("idle_after_gap_load", 20);
        check("gap_done_latency", 64'(last_done_cyc - t0), 64'd64);

        // Unload from a preloaded memory with dout_ready toggling
        for (int r = 0; r < 8; r++) begin
            pre_we = 1'b1; pre_addr = 3'(r); pre_data = exp_row(r, 0, 1);
            tick();
        end
        pre_we = 1'b0;
        for (int k = 0; k < 32; k++) begin
            d.d  = 16'(k);
            d.dn = (k == 31);
            dq.push_back(d);
        end
        unload = 1'b1;
        dout_ready = 1'b1;
        tick();
        unload = 1'b0;
        for (int n = 0; n < 400 && busy; n++) begin
            dout_ready = ~dout_ready;
            tick();
        end
        check("idle_after_unload", {63'd0, busy}, 64'd0);
        check("unload_all_consumed", 64'(dq.size()), 64'd0);
        dout_ready = 1'b1;
        tick();

        // load+unload together selects LOAD; unload mid-load is ignored
        push_writes(16'h1000, 3);
        load = 1'b1; unload = 1'b1;
        tick();
        load = 1'b0; unload = 1'b0;
        check("busy_after_both", {63'd0, busy}, 64'd1);
        for (int k = 0; k < 32; k++) begin
            din = 16'(16'h1000 + 3 * k);
            din_valid = 1'b1;
            unload = (k == 10);
            tick();
            unload = 1'b0;
            if (k == 10) check("busy_after_unload_in_load", {63'd0, busy}, 64'd1);
            if (k == 3) check("no_stream_when_both", {63'd0, dout_valid}, 64'd0);
        end
        din_valid = 1'b0;
        wait_idle("idle_after_both", 20);

        // Reset after 6 words: only row 0 written, no done
        begin
            wr_t e;
            e.addr = 3'd0; e.data = exp_row(0, 16'h0A00, 1); e.dn = 1'b0;
            wq.push_back(e);
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            din = 16'(16'h0A00 + k);
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_we", {63'd0, bram_we}, 64'd0);
        check("abort_writes_seen", 64'(wq.size()), 64'd0);
        repeat (3) tick();

        push_writes(16'h5000, 7);
        do_load(16'h5000, 7, 1'b0, 5);
        wait_idle("idle_after_reload", 20);

        repeat (3) tick();
        check("done_pulses", 64'(n_done), 64'd5);
        check("writes_pending", 64'(wq.size()), 64'd0);
        check("douts_pending", 64'(dq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
